sram_pattern_tester: RTL
========================

// Module: sram_pattern_tester
// PURPOSE
//  Request-side client of the SRAM controller. Performs a self-test: writes an address-derived
//  pattern to addresses 0..addr_last, then reads each location back and compares it.
//  Reports the error count, the first failing address and a pass/fail flag.
//  Sits between the board start/status logic and the controller's sram_req/sram_rh_wl interface.
// PARAMETERS
//  ADDR_WIDTH  19  SRAM word address width; matches the controller
//  DATA_WIDTH  8   SRAM word width; matches the controller
//  ERR_WIDTH   16  width of the saturating error counter
// PORTS
//  clk             in   1           system clock
//  reset           in   1           asynchronous, active-high reset
//  start           in   1           begin a test run; sampled only in IDLE
//  addr_last       in   ADDR_WIDTH  last address tested (inclusive); sampled at start
//  seed            in   DATA_WIDTH  pattern seed; sampled at start
//  sram_req        out  1           request to controller, ACTIVE LOW; low for exactly 1 cycle per op
//  sram_rh_wl      out  1           1 = read, 0 = write; valid while sram_req is low
//  sram_addr       out  ADDR_WIDTH  operation address
//  sram_data_w     out  DATA_WIDTH  write data
//  sram_data_r_en  in   1           controller ready (controller is in idle)
//  sram_data_r     in   DATA_WIDTH  registered read data; valid when ready returns after a read
//  busy            out  1           a test run is in progress
//  done            out  1           run complete; held until the next start
//  pass            out  1           valid with done; 1 = err_count == 0
//  err_count       out  ERR_WIDTH   mismatch count; saturates at all-ones
//  first_err_addr  out  ADDR_WIDTH  address of the first mismatch
//  first_err_exp   out  DATA_WIDTH  expected data at the first mismatch
//  first_err_got   out  DATA_WIDTH  read data at the first mismatch
// BEHAVIOUR
//  Reset values: sram_req = 1, sram_rh_wl = 1; sram_addr, sram_data_w = 0; busy, done, pass = 0.
//    err_count and all first_err_* outputs also reset to 0. State = IDLE.
//  Pattern: exp(a) = a[DATA_WIDTH-1:0] ^ seed_q. seed_q and addr_last_q are latched at start.
//  All outputs are registered. sram_req is decoded from the registered state (Moore).
//  FSM states and transitions:
//    IDLE:     on start, clear counters and flags, set busy -> SYNC.
//    SYNC:     wait for sram_data_r_en = 1 (covers a controller still busy after a reset) -> WR_ISSUE.
//    WR_ISSUE: sram_req = 0, sram_rh_wl = 0, sram_addr = a, sram_data_w = exp(a) -> WR_WAIT.
//    WR_WAIT:  wait for sram_data_r_en = 1. If a == addr_last_q: a = 0 -> RD_ISSUE.
//              Otherwise: a++ -> WR_ISSUE.
//    RD_ISSUE: sram_req = 0, sram_rh_wl = 1, sram_addr = a -> RD_WAIT.
//    RD_WAIT:  on sram_data_r_en = 1, compare sram_data_r with exp(a).
//              On mismatch: err_count++ (saturating); if this is the first error, capture first_err_*.
//              If a == addr_last_q -> DONE. Otherwise: a++ -> RD_ISSUE.
//    DONE:     busy = 0, done = 1, pass = (err_count == 0). A start in DONE behaves as in IDLE.
//  The first WAIT cycle always sees ready = 0, because the controller has left idle.
//    No false completion is possible.
//  Each operation takes 4 cycles (ISSUE + 3 WAIT). With the controller idle at start:
//    done is high 8*(addr_last+1)+1 cycles after the edge that samples start.
//  The end test is an equality compare before increment. addr_last = all-ones must not wrap.
//  start while busy is ignored. addr_last/seed changes during a run are ignored.
//  Same-cycle increment and first capture: the capture uses the pre-increment address.
//  Reset mid-run: outputs immediately take their reset values; sram_req goes high asynchronously.
//    The next run waits in SYNC until the controller reports ready.
// TESTING (bench = tester + controller + behavioural async SRAM model)
//  1. ADDR_WIDTH=19, addr_last=3, seed=0x5A, good SRAM:
//     writes 5A,5B,58,59 to addresses 0..3; done at cycle 33; pass=1; err_count=0.
//  2. As in 1, with the model returning bit0=0 at address 1:
//     err_count=1, first_err_addr=1, exp=0x5B, got=0x5A, pass=0.
//  3. ADDR_WIDTH=4, addr_last=4'hF, seed=0:
//     16 writes then 16 reads; no address wrap; done at cycle 129; pass=1.
//  4. start pulsed mid-run: ignored, op count unchanged.
//     Then start in DONE: a new run begins with counters cleared.
//  5. reset asserted during RD_WAIT: sram_req=1 and busy/done/err_count=0 at once.
//     After release, a new start completes with pass=1.
//  6. ERR_WIDTH=2, model inverts all reads, addr_last=7: err_count saturates at 3; first_err_addr=0.

Source files
------------

// File: rtl/sram_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module   : sram_pattern_tester
// Purpose  : Request-side self-test client for the SRAM controller. Writes
//            exp(a) = a[DATA_WIDTH-1:0] ^ seed to addresses 0..addr_last,
//            reads every location back and compares it. Reports a saturating
//            error count, the first failing address/expected/read data and a
//            pass flag.
// Ports    : clk, reset (async, active high)
//            start, addr_last, seed         - run control (sampled at start)
//            sram_req (active low), sram_rh_wl, sram_addr, sram_data_w
//                                           - request side of the controller
//            sram_data_r_en, sram_data_r    - controller ready / read data
//            busy, done, pass, err_count, first_err_addr/exp/got - status
// Revision : 1.0 - initial release
// ============================================================================
module sram_pattern_tester #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_last,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  sram_req,
  output logic                  sram_rh_wl,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_w,
  input  logic                  sram_data_r_en,
  input  logic [DATA_WIDTH-1:0] sram_data_r,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_got
);

  localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0]  c_err_one  = ERR_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0]  c_err_max  = '1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SYNC     = 3'd1,
    S_WR_ISSUE = 3'd2,
    S_WR_WAIT  = 3'd3,
    S_RD_ISSUE = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr_last;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [DATA_WIDTH-1:0] w_addr_lo;
  logic [DATA_WIDTH-1:0] w_inc_lo;
  logic [DATA_WIDTH-1:0] w_exp_cur;
  logic [DATA_WIDTH-1:0] w_exp_inc;
  logic                  w_last;
  logic                  w_mismatch;

  // sram_addr doubles as the sweep address register.
  assign w_addr_inc = sram_addr + c_addr_one;
  assign w_last     = (sram_addr == r_addr_last);

  // Pattern source: low address bits, zero-extended when the address bus is
  // narrower than a data word.
  generate
    if (ADDR_WIDTH >= DATA_WIDTH) begin : g_addr_wide
      assign w_addr_lo = sram_addr[DATA_WIDTH-1:0];
      assign w_inc_lo  = w_addr_inc[DATA_WIDTH-1:0];
    end else begin : g_addr_narrow
      assign w_addr_lo = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, sram_addr};
      assign w_inc_lo  = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_addr_inc};
    end
  endgenerate

  assign w_exp_cur  = w_addr_lo ^ r_seed;
  assign w_exp_inc  = w_inc_lo ^ r_seed;
  assign w_mismatch = (sram_data_r != w_exp_cur);

  // Request is a pure decode of the state register, so an asynchronous reset
  // deasserts it immediately.
  assign sram_req = !((r_state == S_WR_ISSUE) || (r_state == S_RD_ISSUE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_next = S_SYNC;
      S_SYNC:         if (sram_data_r_en) w_state_next = S_WR_ISSUE;
      S_WR_ISSUE:     w_state_next = S_WR_WAIT;
      S_WR_WAIT:      if (sram_data_r_en) w_state_next = w_last ? S_RD_ISSUE : S_WR_ISSUE;
      S_RD_ISSUE:     w_state_next = S_RD_WAIT;
      S_RD_WAIT:      if (sram_data_r_en) w_state_next = w_last ? S_DONE : S_RD_ISSUE;
      default:        w_state_next = S_IDLE;
    endcase
  end

  // Datapath: every output register is loaded on the cycle before the state
  // that presents it, keeping all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_rh_wl     <= 1'b1;
      sram_addr      <= '0;
      sram_data_w    <= '0;
      r_addr_last    <= '0;
      r_seed         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_addr_last    <= addr_last;
            r_seed         <= seed;
            sram_addr      <= '0;
            sram_rh_wl     <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
          end
        end
        S_SYNC: begin
          if (sram_data_r_en) begin
            sram_rh_wl  <= 1'b0;
            sram_data_w <= w_exp_cur;
          end
        end
        S_WR_WAIT: begin
          if (sram_data_r_en) begin
            if (w_last) begin
              sram_addr  <= '0;
              sram_rh_wl <= 1'b1;
            end else begin
              sram_addr   <= w_addr_inc;
              sram_data_w <= w_exp_inc;
            end
          end
        end
        S_RD_WAIT: begin
          if (sram_data_r_en) begin
            if (w_mismatch) begin
              if (err_count != c_err_max) err_count <= err_count + c_err_one;
              // A saturating counter never returns to zero, so zero means
              // no error has been captured yet in this run.
              if (err_count == '0) begin
                first_err_addr <= sram_addr;
                first_err_exp  <= w_exp_cur;
                first_err_got  <= sram_data_r;
              end
            end
            if (w_last) begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= (err_count == '0) && !w_mismatch;
            end else begin
              sram_addr <= w_addr_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
